qbus_dl11: RTL and testbench

Synthesizable DL11-style console terminal, a QBUS slave on the am4 native bus, downstream of the CPU bus interface.
- Decodes the four terminal registers (default 177560–177567).
- Answers DIN/DOUT with RPLY and requests vectored interrupts via VIRQ/IAKO.
- Serializes and deserializes 8N1 characters on tx/rx pins.
- Replaces the behavioural terminal model in the sim benches and runs on the DE0 board.

---
 rtl/qbus_dl11_pkg.sv | 37 +++
 rtl/qbus_dl11_uart.sv | 127 ++++++++++++
 rtl/qbus_dl11.sv | 245 ++++++++++++++++++++++++
 tb/tb_qbus_dl11.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qbus_dl11_pkg.sv
// Shared constants for the DL11 console terminal: register offsets, bit
// positions, FSM encodings and the CSR word builder.
package qbus_dl11_pkg;

    localparam logic [2:0] OFF_RCSR = 3'd0;
    localparam logic [2:0] OFF_RBUF = 3'd2;
    localparam logic [2:0] OFF_XCSR = 3'd4;
    localparam logic [2:0] OFF_XBUF = 3'd6;

    localparam int BIT_DONE  = 7;
    localparam int BIT_RDY   = 7;
    localparam int BIT_IE    = 6;
    localparam int BIT_MAINT = 2;

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'd0,
        BUS_WAIT  = 2'd1,
        BUS_REPLY = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2
    } rx_state_t;

    // Both CSRs share the layout: status flag in bit 7, IE in bit 6, MAINT in bit 2.
    function automatic logic [15:0] csr_word(input logic flag, input logic ie, input logic maint);
        logic [15:0] w;
        w            = 16'd0;
        w[BIT_DONE]  = flag;
        w[BIT_IE]    = ie;
        w[BIT_MAINT] = maint;
        return w;
    endfunction

endpackage

// File: rtl/qbus_dl11_uart.sv
// DL11 serial engine: 8N1 transmit shifter and mid-bit receive sampler,
// both paced by a BAUD_DIV clock divider.
module qbus_dl11_uart
    import qbus_dl11_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_done,
    input  logic       rxd,
    output logic       rx_done,
    output logic [7:0] rx_data,
    output logic [1:0] rx_dbg
);

    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2 - 1);

    logic [9:0]    tx_sh;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_cnt;
    logic          tx_busy;

    // tx_done is high during the final cycle of the stop bit, so the owner
    // sees the transmitter free on the very next cycle.
    assign tx_done = tx_busy && (tx_cnt == BAUD_LAST) && (tx_bit == 4'd9);
    assign txd     = tx_busy ? tx_sh[0] : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh   <= '1;
            tx_bit  <= 4'd0;
            tx_cnt  <= '0;
            tx_busy <= 1'b0;
        end else if (tx_load) begin
            tx_sh   <= {1'b1, tx_data, 1'b0};
            tx_bit  <= 4'd0;
            tx_cnt  <= '0;
            tx_busy <= 1'b1;
        end else if (tx_busy) begin
            if (tx_cnt == BAUD_LAST) begin
                tx_cnt <= '0;
                tx_sh  <= {1'b1, tx_sh[9:1]};
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                end else begin
                    tx_bit <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    logic          rx_m, rx_s, rx_p;
    rx_state_t     rx_state, rx_state_nx;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rxd;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    always_comb begin
        rx_state_nx = rx_state;
        rx_tick     = (rx_cnt == '0);
        case (rx_state)
            RX_IDLE:  if (rx_p && !rx_s) rx_state_nx = RX_START;
            RX_START: if (rx_tick) rx_state_nx = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_nx = RX_IDLE;
            default:  rx_state_nx = RX_IDLE;
        endcase
    end

    // The stop bit is never sampled: the receiver re-arms right after bit 7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= BAUD_HALF;
            rx_bit   <= 3'd0;
            rx_sh    <= 8'd0;
            rx_done  <= 1'b0;
        end else begin
            rx_state <= rx_state_nx;
            rx_done  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= BAUD_HALF;
                    rx_bit <= 3'd0;
                end
                RX_START: begin
                    rx_cnt <= rx_tick ? BAUD_LAST : rx_cnt - 1'b1;
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        rx_cnt <= BAUD_LAST;
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_done <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: rx_cnt <= BAUD_HALF;
            endcase
        end
    end

    assign rx_data = rx_sh;
    assign rx_dbg  = rx_state;

endmodule

// File: rtl/qbus_dl11.sv
// DL11 console terminal: QBUS slave decode, reply FSM, CSRs and vectored interrupts.
// Build option DL11_LOOPBACK_EN adds XCSR.MAINT internal serial loopback.
module qbus_dl11
    import qbus_dl11_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'o177560,
    parameter logic [8:0]  VECTOR    = 9'o060,
    parameter int          BAUD_DIV  = 434,
    parameter int          RPLY_DLY  = 1
) (
    input  logic        pin_clk,
    input  logic        pin_init_n,
    input  logic [15:0] pin_ad_in,
    output logic [15:0] pin_ad_out,
    output logic        pin_ad_ena,
    input  logic        pin_sync_n,
    input  logic        pin_din_n,
    input  logic        pin_dout_n,
    input  logic        pin_wtbt_n,
    input  logic        pin_iako_n,
    output logic        pin_rply_n,
    output logic        pin_virq_n,
    input  logic        tty_rxd,
    output logic        tty_txd,
    output logic [3:0]  dbg_state
);

    localparam logic [2:0] DLY_LOAD = (RPLY_DLY > 0) ? 3'(RPLY_DLY - 1) : 3'd0;

    logic [15:0] ad_r;
    logic        sync_r, sync_d, din_r, dout_r, wtbt_r, iako_r;
    logic [2:0]  addr_lo;
    logic        sel;
    logic [15:0] ad_inv;

    assign ad_inv = ~ad_r;

    always_ff @(posedge pin_clk or negedge pin_init_n) begin
        if (!pin_init_n) begin
            ad_r   <= 16'd0;
            sync_r <= 1'b1;
            sync_d <= 1'b1;
            din_r  <= 1'b1;
            dout_r <= 1'b1;
            wtbt_r <= 1'b1;
            iako_r <= 1'b1;
        end else begin
            ad_r   <= pin_ad_in;
            sync_r <= pin_sync_n;
            sync_d <= sync_r;
            din_r  <= pin_din_n;
            dout_r <= pin_dout_n;
            wtbt_r <= pin_wtbt_n;
            iako_r <= pin_iako_n;
        end
    end

    always_ff @(posedge pin_clk or negedge pin_init_n) begin
        if (!pin_init_n) begin
            addr_lo <= 3'd0;
            sel     <= 1'b0;
        end else if (sync_r) begin
            addr_lo <= 3'd0;
            sel     <= 1'b0;
        end else if (sync_d) begin
            addr_lo <= ad_inv[2:0];
            sel     <= (ad_inv[15:3] == BASE_ADDR[15:3]);
        end
    end

    logic       rie, done, xie, rdy, maint;
    logic [7:0] rbuf;
    logic       done_d, rie_d, rdy_d, xie_d;
    logic       rx_req, tx_req;
    logic       tx_done, rx_done, txd_int, rxd_int;
    logic [7:0] rx_data;
    logic [1:0] rx_dbg;

    bus_state_t  state, state_nx;
    logic [2:0]  dly_cnt, dly_cnt_nx;
    logic        start, bus_rel;
    logic        rd_cyc, rbuf_cyc;
    logic [15:0] rdata, rd_mux;

    // Vector cycles take precedence; they carry no SYNC so sel is low anyway.
    logic vec_go, rd_go, wr_go;
    assign vec_go = ~iako_r & ~din_r & (rx_req | tx_req);
    assign rd_go  = sel & ~din_r;
    assign wr_go  = sel & ~dout_r;

    always_comb begin
        state_nx   = state;
        dly_cnt_nx = dly_cnt;
        start      = 1'b0;
        bus_rel    = 1'b0;
        case (state)
            BUS_IDLE: begin
                if (vec_go || rd_go || wr_go) begin
                    start = 1'b1;
                    if (RPLY_DLY == 0) begin
                        state_nx = BUS_REPLY;
                    end else begin
                        state_nx   = BUS_WAIT;
                        dly_cnt_nx = DLY_LOAD;
                    end
                end
            end
            BUS_WAIT: begin
                if (dly_cnt == 3'd0) state_nx = BUS_REPLY;
                else dly_cnt_nx = dly_cnt - 3'd1;
            end
            BUS_REPLY: begin
                if (rd_cyc ? din_r : dout_r) begin
                    bus_rel  = 1'b1;
                    state_nx = BUS_IDLE;
                end
            end
            default: state_nx = BUS_IDLE;
        endcase
    end

    logic [2:0]  reg_off;
    logic [7:0]  wdata;
    logic        wr_en, rcsr_wr, xcsr_wr, xbuf_wr, xbuf_acc;
    logic [15:0] vec_word;

    assign reg_off = {addr_lo[2:1], 1'b0};
    assign wdata   = ad_inv[7:0];
    // A byte write to an odd address only touches bits 15:8, which hold nothing.
    assign wr_en    = start & wr_go & ~rd_go & ~vec_go & ~(~wtbt_r & addr_lo[0]);
    assign rcsr_wr  = wr_en & (reg_off == OFF_RCSR);
    assign xcsr_wr  = wr_en & (reg_off == OFF_XCSR);
    assign xbuf_wr  = wr_en & (reg_off == OFF_XBUF);
    assign xbuf_acc = xbuf_wr & (rdy | tx_done);
    assign vec_word = {7'd0, rx_req ? VECTOR : VECTOR + 9'd4};

    always_comb begin
        rd_mux = 16'd0;
        case (reg_off)
            OFF_RCSR: rd_mux = csr_word(done, rie, 1'b0);
            OFF_RBUF: rd_mux = {8'd0, rbuf};
            OFF_XCSR: rd_mux = csr_word(rdy, xie, maint);
            default:  rd_mux = 16'd0;
        endcase
    end

    always_ff @(posedge pin_clk or negedge pin_init_n) begin
        if (!pin_init_n) begin
            state    <= BUS_IDLE;
            dly_cnt  <= 3'd0;
            rd_cyc   <= 1'b0;
            rbuf_cyc <= 1'b0;
            rdata    <= 16'd0;
        end else begin
            state   <= state_nx;
            dly_cnt <= dly_cnt_nx;
            if (start) begin
                rd_cyc   <= vec_go | rd_go;
                rbuf_cyc <= ~vec_go & rd_go & (reg_off == OFF_RBUF);
                rdata    <= vec_go ? vec_word : (rd_go ? rd_mux : 16'd0);
            end
        end
    end

    // RPLY is decoded from state so INIT drops it asynchronously.
    assign pin_rply_n = (state != BUS_REPLY);
    assign pin_ad_ena = (state == BUS_REPLY) & rd_cyc;
    assign pin_ad_out = pin_ad_ena ? ~rdata : 16'hFFFF;

    logic rx_ack, tx_ack, rbuf_rel, rx_set, tx_set, rx_off, tx_off;
    assign rx_ack   = start & vec_go & rx_req;
    assign tx_ack   = start & vec_go & ~rx_req;
    assign rbuf_rel = bus_rel & rbuf_cyc;
    assign rx_set   = rie & done & (~done_d | ~rie_d);
    assign tx_set   = xie & rdy & (~rdy_d | ~xie_d);
    assign rx_off   = rcsr_wr & ~wdata[BIT_IE];
    assign tx_off   = xcsr_wr & ~wdata[BIT_IE];

    always_ff @(posedge pin_clk or negedge pin_init_n) begin
        if (!pin_init_n) begin
            rie    <= 1'b0;
            done   <= 1'b0;
            xie    <= 1'b0;
            rdy    <= 1'b1;
            rbuf   <= 8'd0;
            done_d <= 1'b0;
            rie_d  <= 1'b0;
            rdy_d  <= 1'b1;
            xie_d  <= 1'b0;
            rx_req <= 1'b0;
            tx_req <= 1'b0;
        end else begin
            if (rcsr_wr) rie <= wdata[BIT_IE];
            if (xcsr_wr) xie <= wdata[BIT_IE];
            // A new character overrides the read-clear of DONE (overrun).
            if (rx_done) begin
                rbuf <= rx_data;
                done <= 1'b1;
            end else if (rbuf_rel) begin
                done <= 1'b0;
            end
            if (xbuf_acc)     rdy <= 1'b0;
            else if (tx_done) rdy <= 1'b1;
            done_d <= done;
            rie_d  <= rie;
            rdy_d  <= rdy;
            xie_d  <= xie;
            rx_req <= rx_off ? 1'b0 : rx_set ? 1'b1 : (rx_ack | rbuf_rel) ? 1'b0 : rx_req;
            tx_req <= tx_off ? 1'b0 : tx_set ? 1'b1 : (tx_ack | xbuf_wr) ? 1'b0 : tx_req;
        end
    end

    assign pin_virq_n = ~(rx_req | tx_req);

`ifdef DL11_LOOPBACK_EN
    always_ff @(posedge pin_clk or negedge pin_init_n) begin
        if (!pin_init_n)  maint <= 1'b0;
        else if (xcsr_wr) maint <= wdata[BIT_MAINT];
    end
    assign rxd_int = maint ? txd_int : tty_rxd;
    assign tty_txd = maint ? 1'b1 : txd_int;
`else
    assign maint   = 1'b0;
    assign rxd_int = tty_rxd;
    assign tty_txd = txd_int;
`endif

    qbus_dl11_uart #(
        .BAUD_DIV(BAUD_DIV)
    ) dl11_uart (
        .clk     (pin_clk),
        .rst_n   (pin_init_n),
        .tx_load (xbuf_acc),
        .tx_data (wdata),
        .txd     (txd_int),
        .tx_done (tx_done),
        .rxd     (rxd_int),
        .rx_done (rx_done),
        .rx_data (rx_data),
        .rx_dbg  (rx_dbg)
    );

    assign dbg_state = {rx_dbg, state};

endmodule

// File: tb/tb_qbus_dl11.sv
// Bench for qbus_dl11: bus driver tasks, a read-data scoreboard and a serial
// frame monitor for tty_txd. Build with DL11_LOOPBACK_EN for the MAINT test.
module tb_qbus_dl11;

    localparam int BAUD = 16;
    localparam int DLY  = 1;

    logic        clk = 1'b0;
    logic        init_n = 1'b0;
    logic [15:0] ad_in = 16'hFFFF;
    logic [15:0] ad_out;
    logic        ad_ena;
    logic        sync_n = 1'b1, din_n = 1'b1, dout_n = 1'b1, wtbt_n = 1'b1, iako_n = 1'b1;
    logic        rply_n, virq_n;
    logic        rxd = 1'b1;
    logic        txd;
    logic [3:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  tx_exp_q[$];

    always #5 clk = ~clk;

    qbus_dl11 #(
        .BAUD_DIV(BAUD),
        .RPLY_DLY(DLY)
    ) dut (
        .pin_clk    (clk),
        .pin_init_n (init_n),
        .pin_ad_in  (ad_in),
        .pin_ad_out (ad_out),
        .pin_ad_ena (ad_ena),
        .pin_sync_n (sync_n),
        .pin_din_n  (din_n),
        .pin_dout_n (dout_n),
        .pin_wtbt_n (wtbt_n),
        .pin_iako_n (iako_n),
        .pin_rply_n (rply_n),
        .pin_virq_n (virq_n),
        .tty_rxd    (rxd),
        .tty_txd    (txd),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read-data scoreboard: every replied read/vector cycle consumes one entry.
    logic rply_prev = 1'b1;
    always @(negedge clk) begin
        if (!rply_n && rply_prev && ad_ena) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL read_unexpected: ad_out=%h with no read outstanding", ad_out);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (ad_out !== e) begin
                    failures++;
                    $display("FAIL read_data: ad_out=%h expected %h", ad_out, e);
                end
            end
        end
        rply_prev <= rply_n;
    end

    // Serial monitor: samples each bit near its centre and scores whole bytes.
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (BAUD / 2 - 1) @(negedge clk);
                check("tx_start_bit", {15'd0, txd}, 16'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BAUD) @(negedge clk);
                check("tx_stop_bit", {15'd0, txd}, 16'd1);
                if (tx_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected: frame %h with none expected", b);
                end else begin
                    check("tx_byte", {8'd0, b}, {8'd0, tx_exp_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_rply(input logic level, input string name, output int lat);
        lat = 0;
        while (rply_n !== level && lat < 32) begin
            @(negedge clk);
            lat++;
        end
        check(name, {15'd0, rply_n}, {15'd0, level});
    endtask

    task automatic bus_addr(input logic [15:0] a);
        @(negedge clk);
        ad_in  = ~a;
        sync_n = 1'b1;
        @(negedge clk);
        sync_n = 1'b0;
        repeat (2) @(negedge clk);
        ad_in = 16'hFFFF;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [15:0] exp, input string name, output int lat);
        int l2;
        bus_addr(a);
        exp_q.push_back(~exp);
        din_n = 1'b0;
        wait_rply(1'b0, name, lat);
        din_n = 1'b1;
        wait_rply(1'b1, "rply_release", l2);
        sync_n = 1'b1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic byte_wr, input string name);
        int l;
        bus_addr(a);
        ad_in  = ~d;
        wtbt_n = ~byte_wr;
        @(negedge clk);
        dout_n = 1'b0;
        wait_rply(1'b0, name, l);
        dout_n = 1'b1;
        wait_rply(1'b1, "wr_release", l);
        sync_n = 1'b1;
        wtbt_n = 1'b1;
        ad_in  = 16'hFFFF;
    endtask

    task automatic bus_iak(input logic [15:0] vec, input string name);
        int l;
        @(negedge clk);
        exp_q.push_back(~vec);
        iako_n = 1'b0;
        din_n  = 1'b0;
        wait_rply(1'b0, name, l);
        din_n  = 1'b1;
        iako_n = 1'b1;
        wait_rply(1'b1, "iak_release", l);
    endtask

    task automatic bus_read_none(input logic [15:0] a, input string name);
        logic bad;
        bus_addr(a);
        din_n = 1'b0;
        bad = 1'b0;
        repeat (64) begin
            @(negedge clk);
            if (rply_n !== 1'b1 || ad_ena !== 1'b0) bad = 1'b1;
        end
        check(name, {15'd0, bad}, 16'd0);
        din_n = 1'b1;
        @(negedge clk);
        sync_n = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = fr[i];
            repeat (BAUD - 1) @(negedge clk);
        end
    endtask

    initial begin : main
        int lat;
        repeat (3) @(negedge clk);
        check("rst_rply_n", {15'd0, rply_n}, 16'd1);
        check("rst_virq_n", {15'd0, virq_n}, 16'd1);
        check("rst_ad_ena", {15'd0, ad_ena}, 16'd0);
        check("rst_ad_out", ad_out, 16'hFFFF);
        check("rst_txd", {15'd0, txd}, 16'd1);
        check("rst_state", {12'd0, dbg_state}, 16'd0);
        init_n = 1'b1;
        repeat (2) @(negedge clk);

        // Latency counts one cycle of input registration plus RPLY_DLY+1.
        bus_read(16'o177564, 16'o000200, "rd_xcsr_reset", lat);
        check("rply_latency", 16'(lat), 16'(DLY + 2));
        bus_read(16'o177560, 16'o000000, "rd_rcsr_reset", lat);
        bus_read(16'o177566, 16'o000000, "rd_xbuf_zero", lat);

        // 'A' = 0101: frame data LSB first 1,0,0,0,0,0,1,0; second write while busy is dropped.
        tx_exp_q.push_back(8'o101);
        bus_write(16'o177566, 16'o000101, 1'b0, "wr_xbuf");
        bus_read(16'o177564, 16'o000000, "rd_xcsr_busy", lat);
        bus_write(16'o177566, 16'h007F, 1'b0, "wr_xbuf_busy");
        repeat (200) @(negedge clk);
        bus_read(16'o177564, 16'o000200, "rd_xcsr_done", lat);

        bus_write(16'o177561, 16'h4040, 1'b1, "wr_byte_odd");
        bus_read(16'o177560, 16'o000000, "rd_rcsr_after_odd", lat);

        bus_write(16'o177564, 16'o000100, 1'b0, "wr_xcsr_ie");
        repeat (2) @(negedge clk);
        check("virq_tx", {15'd0, virq_n}, 16'd0);
        bus_iak(16'o000064, "iak_tx");
        repeat (2) @(negedge clk);
        check("virq_tx_clear", {15'd0, virq_n}, 16'd1);

        bus_write(16'o177560, 16'o000100, 1'b0, "wr_rcsr_ie");
        send_rx(8'h55);
        repeat (4) @(negedge clk);
        check("virq_rx", {15'd0, virq_n}, 16'd0);
        bus_read(16'o177560, 16'o000300, "rd_rcsr_done", lat);
        bus_iak(16'o000060, "iak_rx");
        bus_read(16'o177562, 16'o000125, "rd_rbuf", lat);
        bus_read(16'o177560, 16'o000100, "rd_rcsr_cleared", lat);
        check("virq_rx_clear", {15'd0, virq_n}, 16'd1);

        bus_read_none(16'o177570, "no_reply_above");
        bus_read_none(16'o177556, "no_reply_below");

        bus_write(16'o177560, 16'o000000, 1'b0, "wr_rcsr_off");
        bus_write(16'o177564, 16'o000004, 1'b0, "wr_xcsr_maint");
`ifdef DL11_LOOPBACK_EN
        bus_read(16'o177564, 16'o000204, "rd_xcsr_maint", lat);
        bus_write(16'o177566, 16'h003A, 1'b0, "wr_xbuf_loop");
        repeat (200) @(negedge clk);
        bus_read(16'o177560, 16'o000200, "rd_rcsr_loop", lat);
        bus_read(16'o177562, 16'h003A, "rd_rbuf_loop", lat);
`else
        bus_read(16'o177564, 16'o000200, "rd_xcsr_no_maint", lat);
`endif

        repeat (20) @(negedge clk);
        check("exp_q_drained", 16'(exp_q.size()), 16'd0);
        check("tx_exp_q_drained", 16'(tx_exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
